// File: rtl/superbit_pkg.sv
// Shared constants for the SuperBit output-port UART: FSM encoding,
// character width and the default bit period.
package superbit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;

  // 115200 baud from a 100 MHz system clock
  localparam int CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read. A push is accepted when
// the FIFO is not full, or when it is full and a pop frees the head slot on
// the same edge. A pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage array: written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// CPU output port to UART bridge. Each 16-bit word written by the CPU is
// buffered in a small FIFO and sent as two 8N1 characters, low byte first.
// The second character follows the first stop bit with no idle gap.
module out_port_uart_tx
  import superbit_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [15:0] out_data,
  input  logic        out_we,
  output logic        txd,
  output logic        fifo_full,
  output logic        busy,
  output logic        overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  tx_state_t         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit_idx;
  logic              r_byte_sel;
  logic [15:0]       r_shadow;
  logic              r_txd;
  logic              r_overflow;

  logic [15:0]       w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_push;
  logic              w_pop;
  logic              w_baud_done;
  logic [7:0]        w_byte;
  logic [BIT_W-1:0]  w_next_idx;

  // A write coinciding with reset is discarded
  assign w_push      = out_we & ~rst;
  // The head word is taken only from IDLE, and only when there is one
  assign w_pop       = (r_state == S_IDLE) & ~w_fifo_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_byte      = r_byte_sel ? r_shadow[15:8] : r_shadow[7:0];
  assign w_next_idx  = r_bit_idx + BIT_W'(1);

  sync_fifo #(
    .DATA_W (16),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sclk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (out_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Shadow copy of the word in flight, so later CPU writes cannot disturb it
  always_ff @(posedge sclk) begin
    if (w_pop) begin
      r_shadow <= w_fifo_dout;
    end
  end

  // Sticky overflow: a write arrived while full and nothing was leaving
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (out_we && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Transmit FSM; txd is registered and set one edge ahead of each bit
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_sel <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_txd  <= 1'b1;
          if (!w_fifo_empty) begin
            r_byte_sel <= 1'b0;
            r_txd      <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_txd     <= w_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == BIT_LAST) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= w_next_idx;
              r_txd     <= w_byte[w_next_idx];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (!r_byte_sel) begin
              // High byte follows immediately, no idle bit between them
              r_byte_sel <= 1'b1;
              r_txd      <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign txd       = r_txd;
  assign fifo_full = w_fifo_full;
  assign overflow  = r_overflow;
  assign busy      = (w_fifo_count != '0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change on the falling clock edge; outputs are sampled 1 ns after
// the rising edge. A UART monitor rebuilds words from txd at mid-bit and
// compares them with a queue of the writes the bench expects to be sent.
module tb_out_port_uart_tx;

  localparam int CPB = 4;

  logic        sclk;
  logic        rst;
  logic [15:0] out_data;
  logic        out_we;
  logic        txd;
  logic        fifo_full;
  logic        busy;
  logic        overflow;

  int vecs = 0;
  int errs = 0;
  logic [15:0] sb[$];

  out_port_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .out_data  (out_data),
    .out_we    (out_we),
    .txd       (txd),
    .fifo_full (fifo_full),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input logic we, input logic [15:0] d, input logic r);
    @(negedge sclk);
    out_we   = we;
    out_data = d;
    rst      = r;
    @(posedge sclk);
    #1;
  endtask

  // Run idle cycles (with out_data churning) until busy drops, bounded
  task automatic wait_idle(input string nm, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      tick(1'b0, 16'($urandom), 1'b0);
      n++;
    end
    check(nm, 32'(busy), 32'd0);
    repeat (4) tick(1'b0, 16'h0000, 1'b0);
  endtask

  // UART monitor
  logic       mon_have_lo = 1'b0;
  logic [7:0] mon_lo;

  always begin : uart_mon
    logic [7:0]  sh;
    logic [15:0] word;
    bit          ab;
    int          b;
    @(negedge txd);
    ab = 0;
    sh = '0;
    for (int j = 1; j <= 9 * CPB + CPB / 2; j++) begin
      @(posedge sclk);
      if (rst) begin
        ab = 1;
        break;
      end
      #1;
      if (j % CPB == CPB / 2) begin
        b = j / CPB;
        if (b == 0)      check("mon_start_bit", 32'(txd), 32'd0);
        else if (b <= 8) sh[b-1] = txd;
        else             check("mon_stop_bit", 32'(txd), 32'd1);
      end
    end
    if (ab) begin
      mon_have_lo = 1'b0;
    end else if (!mon_have_lo) begin
      mon_lo      = sh;
      mon_have_lo = 1'b1;
    end else begin
      word        = {sh, mon_lo};
      mon_have_lo = 1'b0;
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL mon_word: got %0h, required no word", word);
      end else begin
        check("mon_word", 32'(word), 32'(sb.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        r;
    logic        we;
    logic [15:0] d;
    logic        e_txd;
    logic        e_busy;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[15];

  initial begin : main
    int n;
    rst      = 1'b1;
    out_we   = 1'b0;
    out_data = 16'h0000;

    // Reset, write-during-reset, then single word A55A written at edge k
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'hA55A, 1'b1, 1'b1, 1'b0, 1'b0};
    // k+1..k+4 start bit, k+5..k+8 bit0 of 5A (0)
    for (int i = 3; i <= 10; i++) tbl[i] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    // k+9..k+12 bit1 of 5A (1)
    for (int i = 11; i <= 14; i++) tbl[i] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].we, tbl[i].d, tbl[i].r);
      if (tbl[i].we && !tbl[i].r) sb.push_back(tbl[i].d);
      check($sformatf("vec%0d_txd", i),  32'(txd),       32'(tbl[i].e_txd));
      check($sformatf("vec%0d_busy", i), 32'(busy),      32'(tbl[i].e_busy));
      check($sformatf("vec%0d_full", i), 32'(fifo_full), 32'(tbl[i].e_full));
      check($sformatf("vec%0d_ovf", i),  32'(overflow),  32'(tbl[i].e_ovf));
    end

    // Frame lasts 80 cycles: busy still high after k+80, low after k+81
    repeat (68) tick(1'b0, 16'h0000, 1'b0);
    check("single_busy_k80", 32'(busy), 32'd1);
    tick(1'b0, 16'h0000, 1'b0);
    check("single_busy_k81", 32'(busy), 32'd0);
    check("single_txd_idle", 32'(txd), 32'd1);
    repeat (4) tick(1'b0, 16'h0000, 1'b0);
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // Burst of five; the first pop makes room for the fifth
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 16'(i), 1'b0);
      sb.push_back(16'(i));
    end
    check("burst_full", 32'(fifo_full), 32'd1);
    check("burst_ovf", 32'(overflow), 32'd0);
    wait_idle("burst_drain", 2000);
    check("burst_ovf_end", 32'(overflow), 32'd0);
    check("burst_sb_empty", 32'(sb.size()), 32'd0);

    // Full FIFO with a write on the pop edge (pop at e82)
    tick(1'b1, 16'h1111, 1'b0); sb.push_back(16'h1111);
    tick(1'b1, 16'h2222, 1'b0); sb.push_back(16'h2222);
    tick(1'b1, 16'h3333, 1'b0); sb.push_back(16'h3333);
    tick(1'b1, 16'h4444, 1'b0); sb.push_back(16'h4444);
    tick(1'b1, 16'h5555, 1'b0); sb.push_back(16'h5555);
    check("coll_full_e4", 32'(fifo_full), 32'd1);
    repeat (77) tick(1'b0, 16'h0000, 1'b0);
    check("coll_full_e81", 32'(fifo_full), 32'd1);
    tick(1'b1, 16'h7777, 1'b0); sb.push_back(16'h7777);
    check("coll_full_e82", 32'(fifo_full), 32'd1);
    check("coll_ovf_e82", 32'(overflow), 32'd0);
    wait_idle("coll_drain", 3000);
    check("coll_ovf_end", 32'(overflow), 32'd0);
    check("coll_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow: FIFO full, FSM mid-frame, DEAD is dropped
    tick(1'b1, 16'h1111, 1'b0); sb.push_back(16'h1111);
    tick(1'b1, 16'h2222, 1'b0); sb.push_back(16'h2222);
    tick(1'b1, 16'h3333, 1'b0); sb.push_back(16'h3333);
    tick(1'b1, 16'h4444, 1'b0); sb.push_back(16'h4444);
    tick(1'b1, 16'h5555, 1'b0); sb.push_back(16'h5555);
    check("ovf_pre", 32'(overflow), 32'd0);
    tick(1'b1, 16'hDEAD, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_full", 32'(fifo_full), 32'd1);
    n = 0;
    while (fifo_full && n < 300) begin
      tick(1'b0, 16'h0000, 1'b0);
      n++;
    end
    check("ovf_slot_freed", 32'(fifo_full), 32'd0);
    tick(1'b1, 16'h6666, 1'b0); sb.push_back(16'h6666);
    wait_idle("ovf_drain", 3000);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);
    tick(1'b0, 16'h0000, 1'b1);
    check("ovf_rst_clear", 32'(overflow), 32'd0);

    // Mid-frame reset during DATA of 0x1234 (DATA begins at e5)
    tick(1'b1, 16'h1234, 1'b0);
    repeat (9) tick(1'b0, 16'h0000, 1'b0);
    check("mrst_txd_before", 32'(busy), 32'd1);
    tick(1'b0, 16'h0000, 1'b1);
    check("mrst_txd", 32'(txd), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    check("mrst_full", 32'(fifo_full), 32'd0);
    sb.delete();
    tick(1'b1, 16'hBEEF, 1'b0); sb.push_back(16'hBEEF);
    wait_idle("mrst_drain", 1000);
    check("mrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
